// File: rtl/gexor_acc_if.sv
// Valid/ready bundle for the frame XOR accumulator: word input side plus result output side.
// The slave modport is the accumulator; the master modport is the source and checker pair.
interface gexor_acc_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic             out_bit;
    logic [CW-1:0]    out_count;
    logic             out_trunc;

    modport slave (
        input  in_valid, in_data, in_last, odd_mode, out_ready,
        output in_ready, out_valid, out_word, out_bit, out_count, out_trunc
    );

    modport master (
        output in_valid, in_data, in_last, odd_mode, out_ready,
        input  in_ready, out_valid, out_word, out_bit, out_count, out_trunc
    );
endinterface

// File: rtl/gexor_acc.sv
// Streaming XOR accumulator: folds WIDTH-bit words over a frame and presents the column XOR,
// a parity bit and the frame length, holding the result until the consumer takes it.
module gexor_acc #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    gexor_acc_if.slave  bus
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic {
        ACC,
        HOLD
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] word_q;
    logic             bit_q;
    logic [CW-1:0]    count_q;
    logic             trunc_q;

    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_d;
    logic             closeFrame;

    always_comb begin
        acc_d      = acc_q ^ bus.in_data;
        cnt_d      = cnt_q + CW'(1);
        closeFrame = bus.in_last || (cnt_d == CW'(MAX_WORDS));
    end

    // Result registers only change on a closing word, so they keep their values after HOLD ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            bit_q   <= 1'b0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (bus.in_valid) begin
                        if (closeFrame) begin
                            word_q  <= acc_d;
                            count_q <= cnt_d;
                            bit_q   <= (^acc_d) ^ bus.odd_mode;
                            trunc_q <= !bus.in_last;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_word  = word_q;
    assign bus.out_bit   = bit_q;
    assign bus.out_count = count_q;
    assign bus.out_trunc = trunc_q;
endmodule

// File: tb/tb_gexor_acc.sv
// Directed and randomized bench for gexor_acc with a queue-based frame model.
module tb_gexor_acc;
    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic clk;
    logic rst_n;

    gexor_acc_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus ();

    gexor_acc #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] frameQ[$];
    logic             expValid;
    logic [WIDTH-1:0] expWord;
    logic             expBit;
    logic [CW-1:0]    expCount;
    logic             expTrunc;

    // Frame model: collect words, and on close compute the result straight from the collected list.
    task automatic modelStep(input logic v, input logic [WIDTH-1:0] d, input logic l,
                             input logic odd, input logic ordy, input logic rstn);
        logic [WIDTH-1:0] x;
        if (!rstn) begin
            frameQ.delete();
            expValid = 1'b0;
            expWord  = '0;
            expBit   = 1'b0;
            expCount = '0;
            expTrunc = 1'b0;
        end else if (expValid) begin
            if (ordy) expValid = 1'b0;
        end else if (v) begin
            frameQ.push_back(d);
            if (l || frameQ.size() == MAX_WORDS) begin
                x = '0;
                foreach (frameQ[i]) x = x ^ frameQ[i];
                expWord  = x;
                expCount = CW'(frameQ.size());
                expBit   = (($countones(x) % 2) == 1) ^ odd;
                expTrunc = !l;
                expValid = 1'b1;
                frameQ.delete();
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (bus.out_valid === expValid) else begin
            errors++;
            $error("[TB] FAIL %s out_valid: got %0b expected %0b", tag, bus.out_valid, expValid);
        end
        checks++;
        assert (bus.in_ready === !expValid) else begin
            errors++;
            $error("[TB] FAIL %s in_ready: got %0b expected %0b", tag, bus.in_ready, !expValid);
        end
        checks++;
        assert (bus.out_word === expWord) else begin
            errors++;
            $error("[TB] FAIL %s out_word: got %h expected %h", tag, bus.out_word, expWord);
        end
        checks++;
        assert (bus.out_bit === expBit) else begin
            errors++;
            $error("[TB] FAIL %s out_bit: got %0b expected %0b", tag, bus.out_bit, expBit);
        end
        checks++;
        assert (bus.out_count === expCount) else begin
            errors++;
            $error("[TB] FAIL %s out_count: got %0d expected %0d", tag, bus.out_count, expCount);
        end
        checks++;
        assert (bus.out_trunc === expTrunc) else begin
            errors++;
            $error("[TB] FAIL %s out_trunc: got %0b expected %0b", tag, bus.out_trunc, expTrunc);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare just after it.
    task automatic applyStimulus(input string tag, input logic v, input logic [WIDTH-1:0] d,
                                 input logic l, input logic odd, input logic ordy,
                                 input logic rstn);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.odd_mode  = odd;
        bus.out_ready = ordy;
        rst_n         = rstn;
        @(posedge clk);
        modelStep(v, d, l, odd, ordy, rstn);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.odd_mode  = 1'b0;
        bus.out_ready = 1'b0;
        expValid = 1'b0; expWord = '0; expBit = 1'b0; expCount = '0; expTrunc = 1'b0;
        #2;

        applyStimulus("reset0", 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("reset1", 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);

        applyStimulus("evenW0", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("evenW1", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("evenW2", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus("evenHold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus("oddW0", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("oddW1", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("oddW2", 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus("oddHold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus("single", 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus("singleHold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus("truncW0", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("truncW1", 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("truncW2", 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("truncW3", 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("truncHold", 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("truncW4", 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("truncTail", 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus("tailHold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus("lastAtMax0", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("lastAtMax1", 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("lastAtMax2", 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("lastAtMax3", 1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("stall", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        applyStimulus("stallRelease", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus("afterStall", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus("afterStallHold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus("midRstW0", 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("midRstW1", 1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("midRst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("postRst", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus("postRstHold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          ($urandom_range(0, 3) != 0),
                          WIDTH'($urandom),
                          ($urandom_range(0, 3) == 0),
                          1'($urandom),
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 60) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gexor_acc.md
Name: gexor_acc

Overview:
- Parametrised streaming successor to the two-input XOR gate: XOR-accumulates WIDTH-bit words over a frame and reports the column-wise XOR word plus a single even/odd parity bit.
- Sits between a word source and a checker, using valid/ready on both sides.
- One result per frame, held until consumed.
- Frames are bounded by in_last or by MAX_WORDS, whichever comes first.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- MAX_WORDS, 16, maximum words per frame (>=1); reaching it closes the frame
- CW, $clog2(MAX_WORDS+1), width of the word counter and out_count (derived, do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  input word
- in_last  input  1  marks the final word of a frame; qualified by in_valid
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled with the closing word
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_word  output  WIDTH  XOR of all words in the frame
- out_bit  output  1  reduction XOR of out_word, inverted when odd_mode was 1
- out_count  output  CW  number of words in the frame (1..MAX_WORDS)
- out_trunc  output  1  frame closed by MAX_WORDS without in_last

Behaviour:
- Interface: one clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset (rst_n=0 at a clk edge):
  - state=ACC; accumulator=0; counter=0.
  - out_valid=0, out_word=0, out_bit=0, out_count=0, out_trunc=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-frame or mid-HOLD discards all partial or unconsumed results.
- States: ACC (accepting words), HOLD (result presented).
- Output rules:
  - in_ready = (state==ACC); combinational from state only.
  - out_valid = (state==HOLD); registered.
- ACC, transfer (in_valid & in_ready):
  - acc_next = acc ^ in_data; cnt_next = cnt + 1.
  - Close when in_last=1 or cnt_next==MAX_WORDS. On close:
    - out_word <= acc_next; out_count <= cnt_next.
    - out_bit <= (^acc_next) ^ odd_mode.
    - out_trunc <= (in_last==0).
    - acc <= 0; cnt <= 0; state <= HOLD.
  - Otherwise: acc <= acc_next; cnt <= cnt_next.
- ACC, no transfer: all state held.
- Latency: result registered at the edge consuming the closing word; out_valid high the next cycle (1-cycle latency).
- HOLD:
  - in_ready=0; input ignored (in_data/in_last don't-care).
  - Outputs stable until out_valid & out_ready; on that edge state <= ACC.
  - out_valid drops the next cycle; out_word/out_bit/out_count/out_trunc keep their last values.
  - out_ready may be held high permanently.
  - Back-to-back throughput: one frame per (N+1) cycles (N words plus 1 HOLD cycle). No bypass.
- Single-word frame (in_last on first word): out_word=in_data, out_count=1.
- in_last coinciding with cnt_next==MAX_WORDS: out_trunc=0.
- Counter never exceeds MAX_WORDS; no wrap-around possible.
- odd_mode changes mid-frame have no effect; only the value at the closing transfer counts.
- WIDTH=1 degenerates to a serial parity accumulator: out_word==out_bit when odd_mode=0.

Test Plan:
- WIDTH=8, MAX_WORDS=4. Reset with rst_n=0 for 2 cycles while in_valid=1 -> all outputs 0, in_ready=1, no result produced.
- Frame 0x0F, 0xF0, 0x3C with in_last on the third word, odd_mode=0, out_ready=1 -> out_valid for 1 cycle with out_word=0xC3, out_bit=0, out_count=3, out_trunc=0; in_ready=0 during that cycle.
- Same frame with odd_mode=1 -> out_bit=1. Single word 0x01 with in_last, odd_mode=0 -> out_word=0x01, out_bit=1, out_count=1.
- Five words 0x01, 0x02, 0x04, 0x08, 0x10 with no in_last -> first result out_word=0x0F, out_count=4, out_trunc=1; 0x10 accepted after HOLD ends, starting a new frame.
- Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> outputs stable, in_ready=0, no words consumed. Then pulse out_ready -> in_ready=1 next cycle and the accumulator starts from 0.
- Assert rst_n=0 after 2 of 3 words, then send 0xAA with in_last -> out_word=0xAA, out_count=1 (pre-reset data discarded).
